// File: rtl/mem_stage_sram_ctrl_pkg.sv
// rtl/mem_stage_sram_ctrl_pkg.sv - shared types and constants for the MEM-stage SRAM controller
package mem_stage_sram_ctrl_pkg;

  localparam int          SRAM_DATA_W       = 16;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // True while a halfword is being driven onto the SRAM
  function automatic logic is_phase(input state_t s);
    return (s == LO) || (s == HI);
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// rtl/mem_stage_sram_ctrl_if.sv - pipeline request/response and SRAM pin bundle
interface mem_stage_sram_ctrl_if #(
  parameter int SRAM_ADDR_W = 18
);
  import mem_stage_sram_ctrl_pkg::*;

  logic                   mem_r_en;
  logic                   mem_w_en;
  logic [31:0]            addr;
  logic [31:0]            wdata;
  logic [31:0]            rdata;
  logic                   ready;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [SRAM_DATA_W-1:0] sram_wdata;
  logic                   sram_wdata_oe;
  logic [SRAM_DATA_W-1:0] sram_rdata;
  logic                   sram_we_n;

  // Pipeline plus SRAM device side
  modport master (
    output mem_r_en, mem_w_en, addr, wdata, sram_rdata,
    input  rdata, ready, sram_addr, sram_wdata, sram_wdata_oe, sram_we_n
  );

  // Controller side
  modport slave (
    input  mem_r_en, mem_w_en, addr, wdata, sram_rdata,
    output rdata, ready, sram_addr, sram_wdata, sram_wdata_oe, sram_we_n
  );

endinterface

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
// rtl/mem_stage_sram_ctrl_wait_counter.sv - phase wait-state counter with clear and last-count flags
module mem_wait_counter #(
  parameter int MAX_COUNT = 5,
  parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_last,
  output logic o_next_last
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_COUNT - 1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  assign w_next      = i_clear ? '0 : r_count + 1'b1;
  assign o_last      = (r_count == LAST);
  assign o_next_last = (w_next == LAST);

  // Count up through a phase, restart from zero when cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_count <= '0;
    else     r_count <= w_next;
  end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - 32-bit MEM-stage access split into two 16-bit SRAM phases; optional LAST_READ_CACHE_EN
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int          WAIT_CYCLES = 5,
  parameter int          SRAM_ADDR_W = 18,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input logic            clk,
  input logic            rst,
  mem_stage_sram_ctrl_if.slave bus
);

  state_t                 r_state, w_state_nxt;
  op_t                    r_op, w_op_req, w_op_nxt;
  logic [SRAM_ADDR_W-2:0] r_word, w_word_in, w_word_nxt;
  logic [31:0]            r_wdata, w_wdata_nxt, r_rdata;
  logic                   w_req, w_hit, w_start, w_clear, w_last, w_next_last;
  logic                   w_phase_nxt, w_oe_nxt, w_we_n_nxt;
  logic [SRAM_ADDR_W-1:0] w_sram_addr_nxt, r_sram_addr;
  logic [SRAM_DATA_W-1:0] w_sram_wdata_nxt, r_sram_wdata;
  logic                   r_sram_oe, r_sram_we_n;

  assign w_word_in = (SRAM_ADDR_W-1)'((bus.addr - BASE_ADDR) >> 2);
  assign w_req     = bus.mem_r_en | bus.mem_w_en;
  assign w_op_req  = bus.mem_w_en ? OP_WRITE : OP_READ;

`ifdef LAST_READ_CACHE_EN
  logic                   r_cache_vld;
  logic [SRAM_ADDR_W-2:0] r_cache_word;
  logic [31:0]            r_cache_data;

  assign w_hit     = (r_state == IDLE) && bus.mem_r_en && !bus.mem_w_en &&
                     r_cache_vld && (w_word_in == r_cache_word);
  assign bus.rdata = w_hit ? r_cache_data : r_rdata;
`else
  assign w_hit     = 1'b0;
  assign bus.rdata = r_rdata;
`endif

  assign w_start   = (r_state == IDLE) && w_req && !w_hit;
  assign w_clear   = !is_phase(r_state) || w_last;
  assign bus.ready = (r_state == DONE) || ((r_state == IDLE) && (!w_req || w_hit));

  assign bus.sram_addr     = r_sram_addr;
  assign bus.sram_wdata    = r_sram_wdata;
  assign bus.sram_wdata_oe = r_sram_oe;
  assign bus.sram_we_n     = r_sram_we_n;

  mem_wait_counter #(.MAX_COUNT(WAIT_CYCLES)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .o_last     (w_last),
    .o_next_last(w_next_last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: requests are only sampled in IDLE, phases advance on the last count
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = LO;
      LO:      if (w_last)  w_state_nxt = HI;
      HI:      if (w_last)  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // SRAM pin values for the coming cycle, so the pins themselves come straight from flops
  always_comb begin
    w_op_nxt         = w_start ? w_op_req  : r_op;
    w_word_nxt       = w_start ? w_word_in : r_word;
    w_wdata_nxt      = w_start ? bus.wdata : r_wdata;
    w_phase_nxt      = is_phase(w_state_nxt);
    w_oe_nxt         = w_phase_nxt && (w_op_nxt == OP_WRITE);
    w_sram_addr_nxt  = w_phase_nxt ? {w_word_nxt, (w_state_nxt == HI)} : '0;
    w_sram_wdata_nxt = '0;
    if (w_oe_nxt)
      w_sram_wdata_nxt = (w_state_nxt == HI) ? w_wdata_nxt[31:16] : w_wdata_nxt[15:0];
    // Final cycle of each write phase is a hold cycle with the strobe released
    w_we_n_nxt       = !(w_oe_nxt && !w_next_last);
  end

  // Request latch, registered SRAM pins, read capture and optional read cache
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op         <= OP_READ;
      r_word       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_sram_oe    <= 1'b0;
      r_sram_we_n  <= 1'b1;
`ifdef LAST_READ_CACHE_EN
      r_cache_vld  <= 1'b0;
      r_cache_word <= '0;
      r_cache_data <= '0;
`endif
    end else begin
      r_op         <= w_op_nxt;
      r_word       <= w_word_nxt;
      r_wdata      <= w_wdata_nxt;
      r_sram_addr  <= w_sram_addr_nxt;
      r_sram_wdata <= w_sram_wdata_nxt;
      r_sram_oe    <= w_oe_nxt;
      r_sram_we_n  <= w_we_n_nxt;
      if ((r_state == LO) && w_last && (r_op == OP_READ)) r_rdata[15:0]  <= bus.sram_rdata;
      if ((r_state == HI) && w_last && (r_op == OP_READ)) r_rdata[31:16] <= bus.sram_rdata;
`ifdef LAST_READ_CACHE_EN
      // A hit also refreshes rdata so the held value matches what was returned
      if (w_hit) r_rdata <= r_cache_data;
      if ((r_state == HI) && w_last) begin
        if (r_op == OP_READ) begin
          r_cache_vld  <= 1'b1;
          r_cache_word <= r_word;
          r_cache_data <= {bus.sram_rdata, r_rdata[15:0]};
        end else if (r_cache_vld && (r_word == r_cache_word)) begin
          r_cache_data <= r_wdata;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - scoreboard bench for mem_stage_sram_ctrl
module tb_mem_stage_sram_ctrl;

  localparam int WAIT = 5;

  typedef struct {
    string       name;
    bit          is_read;
    logic [31:0] data;
    int          lat;
    logic [17:0] hw;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  logic [15:0] mem [0:15];

  // monitor state
  bit          active = 0;
  int          cnt = 0;
  int          we_lo = 0;
  bit          oe_seen = 0;
  bit          lo_set = 0;
  logic [17:0] lo_addr, hi_addr;
  logic [15:0] lo_d, hi_d;

`ifdef LAST_READ_CACHE_EN
  bit          cvld = 0;
  logic [31:0] cword = 0;
`endif

  mem_stage_sram_ctrl_if #(.SRAM_ADDR_W(18)) bus ();

  mem_stage_sram_ctrl #(
    .WAIT_CYCLES(WAIT),
    .SRAM_ADDR_W(18),
    .BASE_ADDR  (32'd1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.sram_rdata = mem[bus.sram_addr[3:0]];

  always @(posedge clk) begin
    if (!bus.sram_we_n && bus.sram_wdata_oe) mem[bus.sram_addr[3:0]] <= bus.sram_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic complete(input int lat);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_completion: got latency %0d expected no access", lat);
      return;
    end
    e = q.pop_front();
    chk({e.name, "_latency"}, lat, e.lat);
    if (e.is_read) begin
      chk({e.name, "_rdata"}, bus.rdata, e.data);
      chk({e.name, "_we_low_cycles"}, we_lo, 0);
      chk({e.name, "_oe"}, {31'd0, oe_seen}, 0);
    end else begin
      chk({e.name, "_we_low_cycles"}, we_lo, 2 * (WAIT - 1));
      chk({e.name, "_oe"}, {31'd0, oe_seen}, 1);
      chk({e.name, "_written_word"}, {hi_d, lo_d}, e.data);
      chk({e.name, "_lo_addr"}, {14'd0, lo_addr}, {14'd0, e.hw});
      chk({e.name, "_hi_addr"}, {14'd0, hi_addr}, {14'd0, e.hw + 18'd1});
    end
  endtask

  // Monitor: measures each freeze and checks the completed access against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      active = 0;
    end else if (!active && !bus.ready) begin
      active = 1; cnt = 0; we_lo = 0; oe_seen = 0; lo_set = 0;
    end else if (active && !bus.ready) begin
      cnt++;
      if (bus.sram_wdata_oe) oe_seen = 1;
      if (!bus.sram_we_n) begin
        we_lo++;
        if (!lo_set) begin lo_set = 1; lo_addr = bus.sram_addr; lo_d = bus.sram_wdata; end
        hi_addr = bus.sram_addr;
        hi_d    = bus.sram_wdata;
      end
    end else if (active && bus.ready) begin
      active = 0;
      complete(cnt + 1);
    end else if (bus.ready && (bus.mem_r_en || bus.mem_w_en)) begin
      we_lo = 0; oe_seen = 0;
      complete(0);
    end
  end

  task automatic clear_req();
    bus.mem_w_en = 1'b0;
    bus.mem_r_en = 1'b0;
    bus.addr     = 32'h0;
    bus.wdata    = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one access (caller sits just after a rising edge); d is store data or expected load data
  task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                        input logic [17:0] hw, input int drop_after);
    exp_t e;
    bit   got;
    e.name    = $sformatf("%s_%0d", w ? "wr" : "rd", a);
    e.is_read = !w;
    e.data    = d;
    e.hw      = hw;
    e.lat     = 2 * WAIT + 1;
`ifdef LAST_READ_CACHE_EN
    if (!w && cvld && (cword == a)) e.lat = 0;
    if (!w) begin cvld = 1; cword = a; end
`endif
    q.push_back(e);
    bus.mem_w_en = w;
    bus.mem_r_en = r;
    bus.addr     = a;
    bus.wdata    = w ? d : 32'h0;
    got = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (drop_after == i) begin #1; clear_req(); end
      if (bus.ready) begin got = 1; break; end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: ready still 0 after 100 cycles, required 1", e.name);
    end
    @(posedge clk);
    #1;
    clear_req();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, required finish");
    $fatal(1);
  end

  initial begin
    clear_req();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.ready}, 1);
    chk("rst_we_n", {31'd0, bus.sram_we_n}, 1);
    chk("rst_oe", {31'd0, bus.sram_wdata_oe}, 0);
    chk("rst_sram_addr", {14'd0, bus.sram_addr}, 0);
    chk("rst_sram_wdata", {16'd0, bus.sram_wdata}, 0);
    chk("rst_rdata", bus.rdata, 0);
    rst = 1'b0;
    idle(1);

    access(1, 0, 32'd1028, 32'hDEADBEEF, 18'd2, 0);
    access(0, 1, 32'd1028, 32'hDEADBEEF, 18'd0, 0);
    idle(3);
    chk("rdata_hold", bus.rdata, 32'hDEADBEEF);
    access(0, 1, 32'd1028, 32'hDEADBEEF, 18'd0, 0);
    access(1, 0, 32'd1028, 32'h12345678, 18'd2, 0);
    access(0, 1, 32'd1028, 32'h12345678, 18'd0, 0);

    access(1, 0, 32'd1032, 32'hA5A55A5A, 18'd4, 0);
    access(0, 1, 32'd1032, 32'hA5A55A5A, 18'd0, 0);
    idle(2);

    access(1, 1, 32'd1024, 32'hCAFE0001, 18'd0, 0);
    access(1, 0, 32'd1040, 32'h0BADF00D, 18'd8, 2);
    idle(1);

    // Abort a write in its HI phase
    bus.mem_w_en = 1'b1;
    bus.addr     = 32'd1036;
    bus.wdata    = 32'h11112222;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_we_n", {31'd0, bus.sram_we_n}, 0);
    chk("pre_rst_sram_addr", {14'd0, bus.sram_addr}, 7);
    #1;
    rst = 1'b1;
    clear_req();
    #1;
    chk("abort_ready", {31'd0, bus.ready}, 1);
    chk("abort_we_n", {31'd0, bus.sram_we_n}, 1);
    chk("abort_oe", {31'd0, bus.sram_wdata_oe}, 0);
    chk("abort_sram_addr", {14'd0, bus.sram_addr}, 0);
    chk("abort_sram_wdata", {16'd0, bus.sram_wdata}, 0);
    chk("abort_rdata", bus.rdata, 0);
`ifdef LAST_READ_CACHE_EN
    cvld = 0;
`endif
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    access(0, 1, 32'd1028, 32'h12345678, 18'd0, 0);
    access(0, 1, 32'd1040, 32'h0BADF00D, 18'd0, 0);

    idle(30);
    chk("scoreboard_empty", q.size(), 0);
    chk("no_access_pending", {31'd0, active}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
